// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: opcode map and FSM state encodings.
// Also imported by the control unit so both agree on the opcode values.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_FWD  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MULT = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_ROR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_step.sv
// Combinational single-step datapath of the iterative ALU.
// MULT uses acc/mcand/mplier; the shift ops only move acc by one bit.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  // One shift-add or one single-bit shift/rotate step
  always_comb begin
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    case (op_i)
      OP_MULT: begin
        // Accumulator is WIDTH bits, so the carry out is dropped on purpose
        if (mplier_i[0]) acc_o = acc_i + mcand_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
      end
      OP_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
      OP_SRA:  acc_o = {sign_i, acc_i[WIDTH-1:1]};
      OP_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake.
// Single-step ops finish at the accept edge; MULT and shifts iterate.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  // Wide enough for both the shift amount and the WIDTH constant
  localparam int XW = (WIDTH > CNT_W) ? WIDTH : CNT_W;

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic             sign_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, busy_q, done_q;

  op_e              op_in;
  logic [XW-1:0]    b_x;
  logic [CNT_W-1:0] n_d;
  logic [WIDTH-1:0] quick_d;
  logic [WIDTH-1:0] acc_d, mcand_d, mplier_d;

  assign op_in = op_e'(SELECT);
  assign b_x   = XW'(DATA2);

  // Step count and one-step result for the incoming request
  always_comb begin
    n_d     = '0;
    quick_d = DATA1;
    case (op_in)
      OP_FWD:  quick_d = DATA2;
      OP_ADD:  quick_d = DATA1 + DATA2;
      OP_AND:  quick_d = DATA1 & DATA2;
      OP_OR:   quick_d = DATA1 | DATA2;
      OP_MULT: n_d = CNT_W'(WIDTH);
      OP_SLL, OP_SRA:
        n_d = (b_x >= XW'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b_x);
      // A rotate by a multiple of WIDTH is a no-op and completes at once
      OP_ROR:  n_d = CNT_W'(b_x % XW'(WIDTH));
      default: ;
    endcase
  end

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (op_q),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .sign_i   (sign_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_FWD;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (n_d == '0) begin
              result_q <= quick_d;
              zero_q   <= (quick_d == '0);
              done_q   <= 1'b1;
            end else begin
              op_q     <= op_in;
              cnt_q    <= n_d;
              acc_q    <= (op_in == OP_MULT) ? '0 : DATA1;
              mcand_q  <= DATA1;
              mplier_q <= DATA2;
              sign_q   <= DATA1[WIDTH-1];
              busy_q   <= 1'b1;
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu (WIDTH=8) with a result scoreboard.
module tb_seq_alu;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [2:0]   SELECT;
  logic [W-1:0] DATA1, DATA2;
  logic [W-1:0] RESULT;
  logic         ZERO, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  seq_alu #(.WIDTH(W), .CNT_W(8)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .ZERO   (ZERO),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result for random ops
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [15:0] m;
    logic [15:0] rr;
    int r;
    case (op)
      3'd0: return b;
      3'd1: return a + b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: begin m = 16'(a) * 16'(b); return m[7:0]; end
      3'd5: return (b >= 8) ? 8'h00 : (a << b);
      3'd6: return (b >= 8) ? {8{a[7]}} : W'($signed(a) >>> b);
      default: begin
        r  = int'(b) % 8;
        rr = {a, a} >> r;
        return rr[7:0];
      end
    endcase
  endfunction

  function automatic int steps(input logic [2:0] op, input logic [W-1:0] b);
    if (op < 3'd4) return 0;
    if (op == 3'd4) return 8;
    if (op == 3'd7) return int'(b) % 8;
    return (b >= 8) ? 8 : int'(b);
  endfunction

  // Called at a negedge; START is seen at the next posedge, returns at the following negedge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    START = 1'b1; SELECT = op; DATA1 = a; DATA2 = b;
    sb_q.push_back(exp);
    @(negedge CLK);
    START = 1'b0;
    $display("issue op=%0d a=%02h b=%02h expect=%02h", op, a, b, exp);
  endtask

  // Wait at negedges for DONE, then pop and compare; c0 = cycles already elapsed
  task automatic wait_done(input string tag, input int exp_n, input int c0, input int busy0);
    int c = c0;
    int busy_cnt = busy0;
    logic overlap = 1'b0;
    logic [W-1:0] exp;
    while (!DONE && c < 40) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      c++;
    end
    if (DONE && BUSY) overlap = 1'b1;
    check({tag, "_timeout"}, 32'(DONE), 32'd1);
    if (DONE) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        exp = sb_q.pop_front();
        check({tag, "_result"}, 32'(RESULT), 32'(exp));
        check({tag, "_zero"}, 32'(ZERO), 32'(exp == '0));
      end
      check({tag, "_latency"}, 32'(c), 32'(exp_n));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_n));
      check({tag, "_done_busy_overlap"}, 32'(overlap), 32'd0);
      $display("done %s result=%02h zero=%0d latency=%0d", tag, RESULT, ZERO, c);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_n);
    issue(op, a, b, exp);
    wait_done(tag, exp_n, 0, 0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    int busy_seen;
    int done_seen;

    // Reset with START held high: must be ignored
    RESET = 1'b1; START = 1'b1; SELECT = 3'd1; DATA1 = 8'h01; DATA2 = 8'h01;
    repeat (3) @(negedge CLK);
    check("rst_result", 32'(RESULT), 32'h0);
    check("rst_zero",   32'(ZERO),   32'h0);
    check("rst_busy",   32'(BUSY),   32'h0);
    check("rst_done",   32'(DONE),   32'h0);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
    check("post_rst_no_done", 32'(DONE), 32'h0);

    // 1. single-step ops
    run_op("add_5_3",   3'd1, 8'h05, 8'h03, 8'h08, 0);
    run_op("add_ff_1",  3'd1, 8'hFF, 8'h01, 8'h00, 0);
    run_op("fwd",       3'd0, 8'h12, 8'hA5, 8'hA5, 0);
    run_op("or",        3'd3, 8'h50, 8'h0A, 8'h5A, 0);

    // 2. MULT
    run_op("mult_m3_5",  3'd4, 8'hFD, 8'h05, 8'hF1, 8);
    run_op("mult_10_10", 3'd4, 8'h10, 8'h10, 8'h00, 8);

    // 3. shifts
    run_op("sra_90_2",  3'd6, 8'h90, 8'd2,  8'hE4, 2);
    run_op("sra_90_20", 3'd6, 8'h90, 8'd20, 8'hFF, 8);
    run_op("sll_81_1",  3'd5, 8'h81, 8'd1,  8'h02, 1);
    run_op("sll_81_9",  3'd5, 8'h81, 8'd9,  8'h00, 8);

    // 4. rotate
    run_op("ror_81_9",  3'd7, 8'h81, 8'd9, 8'hC0, 1);
    run_op("ror_81_8",  3'd7, 8'h81, 8'd8, 8'h81, 0);

    // 5a. START during MULT is ignored
    issue(3'd4, 8'h07, 8'h06, 8'h2A);
    repeat (3) @(negedge CLK);
    START = 1'b1; SELECT = 3'd1; DATA1 = 8'h11; DATA2 = 8'h22;
    @(negedge CLK);
    START = 1'b0; DATA1 = 8'h00; DATA2 = 8'h00;
    wait_done("mult_ignore_start", 8, 4, 4);

    // 5b. RESET mid-MULT aborts without DONE
    issue(3'd4, 8'h07, 8'h06, 8'h2A);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_result", 32'(RESULT), 32'h0);
    check("abort_zero",   32'(ZERO),   32'h0);
    check("abort_busy",   32'(BUSY),   32'h0);
    check("abort_done",   32'(DONE),   32'h0);
    sb_q.delete();
    busy_seen = 0; done_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BUSY) busy_seen++;
      if (DONE) done_seen++;
    end
    check("abort_no_late_done", 32'(done_seen), 32'h0);
    check("abort_no_late_busy", 32'(busy_seen), 32'h0);
    run_op("add_after_abort", 3'd1, 8'h20, 8'h22, 8'h42, 0);

    // 6. back-to-back: START in the MULT DONE cycle
    issue(3'd4, 8'h03, 8'h04, 8'h0C);
    wait_done("mult_b2b", 8, 0, 0);
    run_op("and_b2b", 3'd2, 8'hF0, 8'h3C, 8'h30, 0);

    // Random ops against the reference model
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = (rop >= 3'd5) ? 8'($urandom_range(0, 19)) : 8'($urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), steps(rop, rb));
    end

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
